// File: rtl/etx_protocol_pkg.sv
// Shared elink transmit constants: packet field offsets, frame codes, state encoding
// and the address-continuation helper used by burst detection.
package etx_protocol_pkg;

    localparam int PKT_WRITE    = 0;
    localparam int PKT_DM_LSB   = 2;
    localparam int PKT_CTRL_LSB = 4;
    localparam int PKT_DST_LSB  = 8;
    localparam int PKT_DATA_LSB = 40;
    localparam int PKT_SRC_LSB  = 72;

    localparam logic [7:0] FRAME_IDLE      = 8'h00;
    localparam logic [7:0] FRAME_HEAD      = 8'h3F;
    localparam logic [7:0] FRAME_DATA      = 8'hFF;
    localparam logic [1:0] DATAMODE_DOUBLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEAD  = 2'd1,
        ST_DATA  = 2'd2,
        ST_BURST = 2'd3
    } etx_state_e;

    typedef struct packed {
        logic [31:0] srcaddr;
        logic [31:0] data;
        logic [31:0] dstaddr;
        logic [3:0]  ctrlmode;
        logic [1:0]  datamode;
        logic        write;
    } etx_fields_t;

    // Wrap past 0xFFFF_FFF8 shows up in bit 32 and therefore never matches.
    function automatic logic is_next_double(input logic [31:0] prev_addr,
                                            input logic [31:0] new_addr);
        logic [32:0] sum;
        sum = {1'b0, prev_addr} + 33'd8;
        return sum == {1'b0, new_addr};
    endfunction

endpackage

// File: rtl/etx_burst_detect.sv
// Remembers the last accepted packet and flags whether the incoming one continues
// a contiguous double-word write burst.
module etx_burst_detect
    import etx_protocol_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        i_accept,
    input  logic        i_write,
    input  logic [1:0]  i_datamode,
    input  logic [3:0]  i_ctrlmode,
    input  logic [31:0] i_dstaddr,
    output logic        o_eligible
);

    logic        r_write;
    logic [1:0]  r_datamode;
    logic [3:0]  r_ctrlmode;
    logic [31:0] r_dstaddr;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_write    <= 1'b0;
            r_datamode <= 2'b00;
            r_ctrlmode <= 4'h0;
            r_dstaddr  <= 32'h0;
        end else if (i_accept) begin
            r_write    <= i_write;
            r_datamode <= i_datamode;
            r_ctrlmode <= i_ctrlmode;
            r_dstaddr  <= i_dstaddr;
        end
    end

    assign o_eligible = r_write && i_write
                     && (r_datamode == DATAMODE_DOUBLE)
                     && (i_datamode == DATAMODE_DOUBLE)
                     && (r_ctrlmode == i_ctrlmode)
                     && is_next_double(r_dstaddr, i_dstaddr);

endmodule

// File: rtl/etx_protocol.sv
// emesh-to-8-lane transmit protocol engine (HEAD/DATA framing, optional write bursts).
// Define ETX_BURST_EN to build the burst path; without it every packet is HEAD+DATA.
module etx_protocol
    import etx_protocol_pkg::*;
#(
    parameter int PW        = 104,
    parameter int BURST_MAX = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          tx_access,
    input  logic [PW-1:0] tx_packet,
    output logic          tx_wait,
    input  logic          tx_wr_wait,
    input  logic          tx_rd_wait,
    output logic [7:0]    tx_frame_par,
    output logic [63:0]   tx_data_par,
    output logic          tx_burst
);

    etx_state_e  r_state;
    etx_state_e  w_next_state;
    etx_fields_t w_pkt;
    logic        w_accept;
    logic        w_eligible;
    logic        w_room;
    logic [15:0] r_hold_data_lo;
    logic [31:0] r_hold_src;
    logic [7:0]  r_frame;
    logic [7:0]  w_frame;
    logic [63:0] r_data;
    logic [63:0] w_data;
    logic        w_unused_bits;

    assign w_pkt.write    = tx_packet[PKT_WRITE];
    assign w_pkt.datamode = tx_packet[PKT_DM_LSB +: 2];
    assign w_pkt.ctrlmode = tx_packet[PKT_CTRL_LSB +: 4];
    assign w_pkt.dstaddr  = tx_packet[PKT_DST_LSB +: 32];
    assign w_pkt.data     = tx_packet[PKT_DATA_LSB +: 32];
    assign w_pkt.srcaddr  = tx_packet[PKT_SRC_LSB +: 32];

    assign tx_wait  = !nreset || (r_state == ST_HEAD) || tx_wr_wait || tx_rd_wait;
    assign w_accept = tx_access && !tx_wait;

`ifdef ETX_BURST_EN
    localparam int CW = $clog2(BURST_MAX + 1);

    logic [CW-1:0] r_count;

    etx_burst_detect u_burst_detect (
        .clk        (clk),
        .nreset     (nreset),
        .i_accept   (w_accept),
        .i_write    (w_pkt.write),
        .i_datamode (w_pkt.datamode),
        .i_ctrlmode (w_pkt.ctrlmode),
        .i_dstaddr  (w_pkt.dstaddr),
        .o_eligible (w_eligible)
    );

    // Counts beats of the current transfer; the DATA beat is beat 1.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_count <= '0;
        end else begin
            case (w_next_state)
                ST_DATA:  r_count <= CW'(1);
                ST_BURST: if (r_count < CW'(BURST_MAX)) r_count <= r_count + CW'(1);
                default:  r_count <= '0;
            endcase
        end
    end

    assign w_room        = (r_count < CW'(BURST_MAX));
    assign tx_burst      = (r_state == ST_BURST);
    assign w_unused_bits = tx_packet[1];
`else
    assign w_eligible    = 1'b0;
    assign w_room        = 1'b0;
    assign tx_burst      = 1'b0;
    assign w_unused_bits = ^{tx_packet[1], BURST_MAX[0]};
`endif

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_next_state = w_accept ? ST_HEAD : ST_IDLE;
            ST_HEAD:  w_next_state = ST_DATA;
            ST_DATA:  if (w_accept) w_next_state = w_eligible ? ST_BURST : ST_HEAD;
            ST_BURST: if (w_accept) w_next_state = (w_eligible && w_room) ? ST_BURST : ST_HEAD;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Output words are built for the state being entered and registered with it.
    always_comb begin
        w_frame = FRAME_IDLE;
        w_data  = 64'h0;
        case (w_next_state)
            ST_HEAD: begin
                w_frame = FRAME_HEAD;
                w_data  = {8'h00, w_pkt.ctrlmode, w_pkt.datamode, w_pkt.write, 1'b0,
                           w_pkt.dstaddr, w_pkt.data[31:16]};
            end
            ST_DATA: begin
                w_frame = FRAME_DATA;
                w_data  = {r_hold_data_lo, r_hold_src, 16'h0000};
            end
            ST_BURST: begin
                w_frame = FRAME_DATA;
                w_data  = {w_pkt.srcaddr, w_pkt.data};
            end
            default: begin
                w_frame = FRAME_IDLE;
                w_data  = 64'h0;
            end
        endcase
    end

    // NOTE: the holding register is cleared on reset too, so an abandoned packet never replays.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state        <= ST_IDLE;
            r_frame        <= FRAME_IDLE;
            r_data         <= 64'h0;
            r_hold_data_lo <= 16'h0;
            r_hold_src     <= 32'h0;
        end else begin
            r_state <= w_next_state;
            r_frame <= w_frame;
            r_data  <= w_data;
            if (w_accept) begin
                r_hold_data_lo <= w_pkt.data[15:0];
                r_hold_src     <= w_pkt.srcaddr;
            end
        end
    end

    assign tx_frame_par = r_frame;
    assign tx_data_par  = r_data;

endmodule

// File: tb/tb_etx_protocol.sv
// Self-checking bench for etx_protocol: directed scenarios plus randomized traffic,
// compared cycle by cycle against a word-sequence reference model.
module tb_etx_protocol;

    localparam int PW        = 104;
    localparam int BURST_MAX = 16;
`ifdef ETX_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  frame;
        logic [63:0] data;
        logic        burst;
    } beat_t;

    logic          clk = 1'b0;
    logic          nreset;
    logic          tx_access;
    logic [PW-1:0] tx_packet;
    logic          tx_wait;
    logic          tx_wr_wait;
    logic          tx_rd_wait;
    logic [7:0]    tx_frame_par;
    logic [63:0]   tx_data_par;
    logic          tx_burst;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    etx_protocol #(.PW(PW), .BURST_MAX(BURST_MAX)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .tx_access    (tx_access),
        .tx_packet    (tx_packet),
        .tx_wait      (tx_wait),
        .tx_wr_wait   (tx_wr_wait),
        .tx_rd_wait   (tx_rd_wait),
        .tx_frame_par (tx_frame_par),
        .tx_data_par  (tx_data_par),
        .tx_burst     (tx_burst)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model: expected output word stream ----------------
    beat_t        m_now;
    beat_t        m_pend[$];
    logic [103:0] m_prev;
    int           m_beats;

    function automatic logic [103:0] mk(input logic w, input logic [1:0] dm, input logic [3:0] ctrl,
                                        input logic [31:0] dst, input logic [31:0] dat,
                                        input logic [31:0] src);
        return {src, dat, dst, ctrl, dm, 1'b0, w};
    endfunction

    function automatic beat_t head_beat(input logic [103:0] p);
        beat_t b;
        b.frame = 8'h3F;
        b.data  = {8'h00, p[7:4], p[3:2], p[0], 1'b0, p[39:8], p[71:56]};
        b.burst = 1'b0;
        return b;
    endfunction

    function automatic beat_t data_beat(input logic [103:0] p);
        beat_t b;
        b.frame = 8'hFF;
        b.data  = {p[55:40], p[103:72], 16'h0000};
        b.burst = 1'b0;
        return b;
    endfunction

    function automatic beat_t burst_beat(input logic [103:0] p);
        beat_t b;
        b.frame = 8'hFF;
        b.data  = p[103:40];
        b.burst = 1'b1;
        return b;
    endfunction

    function automatic bit follows(input logic [103:0] a, input logic [103:0] b);
        longint unsigned pa;
        longint unsigned nb;
        pa = 64'(a[39:8]);
        nb = 64'(b[39:8]);
        return a[0] && b[0] && (a[3:2] == 2'b11) && (b[3:2] == 2'b11)
            && (a[7:4] == b[7:4]) && (pa + 8 == nb);
    endfunction

    task automatic model_edge(input logic rn, input bit acc, input logic [103:0] p);
        if (!rn) begin
            m_pend.delete();
            m_now   = '0;
            m_beats = 0;
        end else if (m_pend.size() != 0) begin
            m_now = m_pend.pop_front();
        end else if (acc) begin
            if (BURST_ON && m_now.frame == 8'hFF && follows(m_prev, p) && m_beats < BURST_MAX) begin
                m_now = burst_beat(p);
                m_beats++;
            end else begin
                m_now = head_beat(p);
                m_pend.push_back(data_beat(p));
                m_beats = 1;
            end
            m_prev = p;
        end else begin
            m_now   = '0;
            m_beats = 0;
        end
    endtask

    // One clock: drive after a falling edge, check wait, clock the model, check outputs.
    task automatic run_cycle(input logic rn, input logic acc_in, input logic [103:0] p,
                             input logic wrw, input logic rdw, output bit accepted);
        bit exp_wait;
        nreset     = rn;
        tx_access  = acc_in;
        tx_packet  = p;
        tx_wr_wait = wrw;
        tx_rd_wait = rdw;
        exp_wait   = !rn || (m_pend.size() != 0) || wrw || rdw;
        #1;
        check("tx_wait", 64'(tx_wait), 64'(exp_wait));
        accepted = rn && acc_in && !exp_wait;
        @(posedge clk);
        model_edge(rn, accepted, p);
        @(negedge clk);
        check("frame", 64'(tx_frame_par), 64'(m_now.frame));
        check("data", tx_data_par, m_now.data);
        check("burst", 64'(tx_burst), 64'(m_now.burst));
    endtask

    logic [103:0] src_q[$];
    int           head_seen;
    int           burst_seen;

    task automatic pump(input int wait_at, input int wait_len);
        int cyc;
        bit acc;
        bit a;
        bit w;
        cyc        = 0;
        head_seen  = 0;
        burst_seen = 0;
        while ((src_q.size() != 0 || m_pend.size() != 0) && cyc < 500) begin
            a = (src_q.size() != 0);
            w = (cyc >= wait_at) && (cyc < wait_at + wait_len);
            run_cycle(1'b1, a, a ? src_q[0] : 104'h0, w, 1'b0, acc);
            if (acc) void'(src_q.pop_front());
            if (tx_frame_par == 8'h3F) head_seen++;
            if (tx_burst) burst_seen++;
            cyc++;
        end
        check("pump_budget", 64'(cyc < 500), 64'd1);
        for (int i = 0; i < 2; i++) run_cycle(1'b1, 1'b0, 104'h0, 1'b0, 1'b0, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit           acc;
        bit           have;
        bit           a;
        logic         rn;
        logic [103:0] cur;
        logic [103:0] sp;
        logic [31:0]  dst;
        logic [31:0]  last_dst;

        nreset     = 1'b0;
        tx_access  = 1'b0;
        tx_packet  = '0;
        tx_wr_wait = 1'b0;
        tx_rd_wait = 1'b0;
        m_now      = '0;
        m_prev     = '0;
        m_beats    = 0;
        @(negedge clk);

        // Reset state
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 104'h0, 1'b0, 1'b0, acc);
        check("rst_frame", 64'(tx_frame_par), 64'h00);
        check("rst_data", tx_data_par, 64'h0);
        check("rst_wait", 64'(tx_wait), 64'd1);

        // Single write: header, data beat, then idle
        sp = mk(1'b1, 2'b10, 4'h0, 32'h8080_0000, 32'hDEAD_BEEF, 32'h1234_5678);
        run_cycle(1'b1, 1'b1, sp, 1'b0, 1'b0, acc);
        check("single_hdr_frame", 64'(tx_frame_par), 64'h3F);
        check("single_hdr_data", tx_data_par, 64'h000A_8080_0000_DEAD);
        run_cycle(1'b1, 1'b0, 104'h0, 1'b0, 1'b0, acc);
        check("single_dat_frame", 64'(tx_frame_par), 64'hFF);
        check("single_dat_data", tx_data_par, 64'hBEEF_1234_5678_0000);
        run_cycle(1'b1, 1'b0, 104'h0, 1'b0, 1'b0, acc);
        check("single_idle_frame", 64'(tx_frame_par), 64'h00);

        // Four contiguous double writes
        for (int i = 0; i < 4; i++)
            src_q.push_back(mk(1'b1, 2'b11, 4'h2, 32'h100 + 32'(8 * i), 32'hA000_0000 + 32'(i), 32'h5555_0000));
        pump(1000, 0);
        check("burst4_heads", 64'(head_seen), BURST_ON ? 64'd1 : 64'd4);
        check("burst4_beats", 64'(burst_seen), BURST_ON ? 64'd3 : 64'd0);

        // Twenty contiguous writes: burst length limit forces a fresh header
        for (int i = 0; i < 20; i++)
            src_q.push_back(mk(1'b1, 2'b11, 4'h0, 32'h2000 + 32'(8 * i), $urandom, $urandom));
        pump(1000, 0);
        check("burst20_heads", 64'(head_seen), BURST_ON ? 64'd2 : 64'd20);
        check("burst20_beats", 64'(burst_seen), BURST_ON ? 64'd18 : 64'd0);

        // Address wrap is not a continuation
        src_q.push_back(mk(1'b1, 2'b11, 4'h1, 32'hFFFF_FFF8, 32'h1, 32'h2));
        src_q.push_back(mk(1'b1, 2'b11, 4'h1, 32'h0000_0000, 32'h3, 32'h4));
        pump(1000, 0);
        check("wrap_heads", 64'(head_seen), 64'd2);
        check("wrap_beats", 64'(burst_seen), 64'd0);

        // Remote write pushback for two cycles in the middle of a burst
        for (int i = 0; i < 6; i++)
            src_q.push_back(mk(1'b1, 2'b11, 4'h3, 32'h4000 + 32'(8 * i), $urandom, $urandom));
        pump(4, 2);
        check("pushback_heads", 64'(head_seen), BURST_ON ? 64'd2 : 64'd6);
        check("pushback_beats", 64'(burst_seen), BURST_ON ? 64'd4 : 64'd0);

        // Reset asserted during the DATA cycle
        run_cycle(1'b1, 1'b1, sp, 1'b0, 1'b0, acc);
        run_cycle(1'b1, 1'b0, 104'h0, 1'b0, 1'b0, acc);
        check("prerst_frame", 64'(tx_frame_par), 64'hFF);
        run_cycle(1'b0, 1'b1, sp, 1'b0, 1'b0, acc);
        check("midrst_frame", 64'(tx_frame_par), 64'h00);
        check("midrst_data", tx_data_par, 64'h0);
        run_cycle(1'b0, 1'b1, sp, 1'b0, 1'b0, acc);
        check("midrst_wait", 64'(tx_wait), 64'd1);
        run_cycle(1'b1, 1'b0, 104'h0, 1'b0, 1'b0, acc);
        check("postrst_frame", 64'(tx_frame_par), 64'h00);

        // Randomized traffic with gaps, pushback and occasional reset
        have     = 1'b0;
        cur      = '0;
        last_dst = $urandom;
        for (int i = 0; i < 1500; i++) begin
            if (!have) begin
                if ($urandom_range(5) == 0)       dst = $urandom;
                else if ($urandom_range(30) == 0) dst = 32'hFFFF_FFF8;
                else                              dst = last_dst + 32'd8;
                cur = mk($urandom_range(7) != 0,
                         ($urandom_range(5) == 0) ? 2'($urandom) : 2'b11,
                         ($urandom_range(7) == 0) ? 4'($urandom) : 4'h5,
                         dst, $urandom, $urandom);
                have = 1'b1;
            end
            rn = ($urandom_range(199) != 0);
            a  = have && ($urandom_range(9) < 8);
            run_cycle(rn, a, cur, $urandom_range(9) == 0, $urandom_range(14) == 0, acc);
            if (acc) begin
                have     = 1'b0;
                last_dst = cur[39:8];
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
